// File: rtl/d_cache.sv
// d_cache: direct-mapped write-through write-allocate data cache, one word per line
module d_cache #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_a,
  input  logic [31:0] p_dout,
  output logic [31:0] p_din,
  input  logic        p_strobe,
  input  logic        p_rw,
  input  logic        uncached,
  output logic        p_ready,
  output logic [31:0] m_a,
  input  logic [31:0] m_dout,
  output logic [31:0] m_din,
  output logic        m_strobe,
  output logic        m_rw,
  input  logic        m_ready
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic hit, cache_write;
  assign index = p_a[INDEX_BITS+1:2];
  assign tag = p_a[31:INDEX_BITS+2];
  assign hit = p_strobe & ~uncached & valid[index] & (tags[index] == tag);
  assign m_a = p_a;
  assign m_din = p_dout;
  assign m_rw = p_strobe & p_rw;
  assign m_strobe = p_strobe & (p_rw | ~hit);
  assign p_ready = p_strobe & ((~p_rw & hit) | ((p_rw | ~hit) & m_ready));
  assign p_din = hit ? data[index] : m_dout;
  assign cache_write = ~rst & p_strobe & ~uncached & m_ready & (p_rw | ~hit);
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (cache_write) begin
      valid[index] <= 1'b1;
      tags[index] <= tag;
      data[index] <= p_rw ? p_dout : m_dout;
    end
  end
endmodule

// File: tb/tb_d_cache.sv
// tb_d_cache: randomized scoreboard bench for d_cache against a word-address reference model
module tb_d_cache;
  logic clk = 0, rst = 1;
  logic [31:0] p_a = 0, p_dout = 0, p_din, m_a, m_dout = 0, m_din;
  logic p_strobe = 0, p_rw = 0, uncached = 0, p_ready, m_strobe, m_rw, m_ready = 0;
  typedef struct {
    logic rw;
    logic [31:0] din;
    logic ms;
    logic [31:0] a;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic mv [64];
  logic [29:0] mw [64];
  logic [31:0] md [64];

  d_cache dut (
    .clk(clk), .rst(rst), .p_a(p_a), .p_dout(p_dout), .p_din(p_din),
    .p_strobe(p_strobe), .p_rw(p_rw), .uncached(uncached), .p_ready(p_ready),
    .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe),
    .m_rw(m_rw), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (p_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected p_ready at t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("m_strobe", {31'b0, m_strobe}, {31'b0, e.ms});
        chk("m_rw", {31'b0, m_rw}, {31'b0, e.rw});
        chk("m_a", m_a, e.a);
        chk("m_din", m_din, e.wd);
        if (!e.rw) chk("p_din", p_din, e.din);
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        input logic unc, input logic [31:0] mdv, input int waits,
                        input logic rst_end = 1'b0);
    int idx;
    logic hit;
    exp_t e;
    idx = int'(a[7:2]);
    hit = !unc && mv[idx] && mw[idx] == a[31:2];
    @(posedge clk);
    #1;
    p_a = a; p_rw = rw; p_dout = wd; uncached = unc; m_dout = mdv; p_strobe = 1;
    e.rw = rw; e.a = a; e.wd = wd;
    if (hit && !rw) begin
      m_ready = 1'($urandom_range(0, 1));
      e.din = md[idx]; e.ms = 0;
      q.push_back(e);
    end else begin
      m_ready = 0;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk("stall p_ready", {31'b0, p_ready}, 0);
        chk("stall m_strobe", {31'b0, m_strobe}, 1);
        @(posedge clk);
        #1;
      end
      m_ready = 1;
      rst = rst_end;
      e.din = mdv; e.ms = 1;
      q.push_back(e);
    end
    @(posedge clk);
    if (rst_end) begin
      for (int i = 0; i < 64; i++) mv[i] = 0;
    end else if (!unc && (rw || !hit)) begin
      mv[idx] = 1;
      mw[idx] = a[31:2];
      md[idx] = rw ? wd : mdv;
    end
    #1;
    p_strobe = 0; rst = 0;
    m_ready = 1'($urandom_range(0, 1));
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing p_ready for addr %h", a);
      q.delete();
    end
    @(negedge clk);
    chk("idle p_ready", {31'b0, p_ready}, 0);
    chk("idle m_strobe", {31'b0, m_strobe}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mv[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset p_ready", {31'b0, p_ready}, 0);
    chk("reset m_strobe", {31'b0, m_strobe}, 0);
    @(posedge clk);
    #1 rst = 0;
    access(32'h100, 0, 0, 0, 32'hFFFFFFFF, 2);
    access(32'h100, 0, 0, 0, 32'h0, 1);
    access(32'h104, 1, 32'h5555AAAA, 0, 32'h0, 2);
    access(32'h104, 0, 0, 0, 32'h0, 1);
    access(32'h200, 0, 0, 0, 32'h12345678, 1);
    access(32'h100, 0, 0, 0, 32'hFFFFFFFF, 1);
    access(32'h100, 0, 0, 1, 32'hABCD0000, 1);
    access(32'h100, 0, 0, 0, 32'h0, 0);
    access(32'h300, 0, 0, 0, 32'h77, 0, 1'b1);
    access(32'h300, 0, 0, 0, 32'h88, 1);
    access(32'h100, 0, 0, 0, 32'h99, 1);
    access(32'h104, 0, 0, 0, 32'h66, 0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 49) == 0);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard not empty: %0d left", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
